// File: rtl/hb_pkg.sv
// hb_pkg -- shared definitions for the half-band x2 interpolator output stage.
//
// Holds the default datapath widths and the commutator FSM state encoding.
// Used by hb_round_sat and hb_interp_commutator.

package hb_pkg;

  // Polyphase branch width, serialised output width and the branch gain shift
  localparam int HB_IN_W       = 23;
  localparam int HB_OUT_W      = 15;
  localparam int HB_FRAC_SHIFT = 8;

  // Commutator phase: nothing to send, sending E0, sending E1
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } hb_state_e;

endpackage

// File: rtl/hb_round_sat.sv
// hb_round_sat -- combinational round-half-up, arithmetic shift and clamp.
//
// Ports:
//   x    in   IN_W   signed sample carrying the branch gain of 2^FRAC_SHIFT
//   y    out  OUT_W  signed rounded and clamped sample
//   sat  out  1      high when y was clamped to either rail

module hb_round_sat
  import hb_pkg::*;
#(
  parameter int IN_W       = HB_IN_W,
  parameter int OUT_W      = HB_OUT_W,
  parameter int FRAC_SHIFT = HB_FRAC_SHIFT
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int MIN_I = -(1 << (OUT_W - 1));

  // One extra bit of headroom so adding the rounding half never wraps
  localparam logic signed [IN_W:0] HALF  = (IN_W + 1)'(1 << (FRAC_SHIFT - 1));
  localparam logic signed [IN_W:0] MAX_V = (IN_W + 1)'(MAX_I);
  localparam logic signed [IN_W:0] MIN_V = (IN_W + 1)'(MIN_I);

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;

  always_comb begin
    sum     = $signed({x[IN_W-1], x}) + HALF;
    shifted = sum >>> FRAC_SHIFT;
    sat     = 1'b0;
    y       = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      y   = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      y   = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/hb_interp_commutator.sv
// hb_interp_commutator -- output commutator of the half-band x2 interpolator.
//
// Takes one (E0, E1) polyphase pair per input handshake, rounds/saturates both
// at acceptance, and emits E0 then E1 on a single valid/ready stream. A current
// pair register plus a one-pair pending (skid) register decouple the two sides.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sync_clr          synchronous flush of all buffered data (and sat_cnt)
//   in_valid/in_ready input pair handshake; in_e0, in_e1 signed IN_W samples
//   out_valid/out_ready output handshake; out_data signed OUT_W sample
//   sat_cnt           16-bit saturating clamp counter, present only when the
//                     HB_SAT_STATS_EN macro is defined

module hb_interp_commutator
  import hb_pkg::*;
#(
  parameter int IN_W       = HB_IN_W,
  parameter int OUT_W      = HB_OUT_W,
  parameter int FRAC_SHIFT = HB_FRAC_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_e0,
  input  logic [IN_W-1:0]  in_e1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef HB_SAT_STATS_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  hb_state_e state_q, state_d;

  logic [OUT_W-1:0] cur_e0_q, cur_e1_q;
  logic [OUT_W-1:0] pend_e0_q, pend_e1_q;
  logic             pend_valid_q, pend_valid_d;
  logic [OUT_W-1:0] rs_e0, rs_e1;
  logic             accept;
  logic             load_cur_in, load_cur_pend, load_pend;

`ifdef HB_SAT_STATS_EN
  logic sat0, sat1;
  hb_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_e0 (
    .x(in_e0), .y(rs_e0), .sat(sat0)
  );
  hb_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_e1 (
    .x(in_e1), .y(rs_e1), .sat(sat1)
  );
`else
  hb_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_e0 (
    .x(in_e0), .y(rs_e0), .sat()
  );
  hb_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_rs_e1 (
    .x(in_e1), .y(rs_e1), .sat()
  );
`endif

  // Ready depends only on the pending flag and the flush request, so the
  // upstream never sees a combinational path from out_ready.
  assign in_ready = !pend_valid_q && !sync_clr;
  assign accept   = in_valid && in_ready;

  // Next state and register load selects. An accepted pair goes straight to
  // the current register when the commutator is idle or is just finishing E1
  // with nothing pending; otherwise it parks in the pending register.
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    load_cur_in   = 1'b0;
    load_cur_pend = 1'b0;
    load_pend     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_cur_in = 1'b1;
          state_d     = SEND0;
        end
      end
      SEND0: begin
        if (out_ready) state_d = SEND1;
        if (accept) begin
          load_pend    = 1'b1;
          pend_valid_d = 1'b1;
        end
      end
      SEND1: begin
        if (out_ready) begin
          if (pend_valid_q) begin
            load_cur_pend = 1'b1;
            pend_valid_d  = 1'b0;
            state_d       = SEND0;
          end else if (accept) begin
            load_cur_in = 1'b1;
            state_d     = SEND0;
          end else begin
            state_d = EMPTY;
          end
        end else if (accept) begin
          load_pend    = 1'b1;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (sync_clr) begin
      state_d       = EMPTY;
      pend_valid_d  = 1'b0;
      load_cur_in   = 1'b0;
      load_cur_pend = 1'b0;
      load_pend     = 1'b0;
    end
  end

  // State, pending flag and the two pair registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      pend_valid_q <= 1'b0;
      cur_e0_q     <= '0;
      cur_e1_q     <= '0;
      pend_e0_q    <= '0;
      pend_e1_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      if (load_cur_in) begin
        cur_e0_q <= rs_e0;
        cur_e1_q <= rs_e1;
      end else if (load_cur_pend) begin
        cur_e0_q <= pend_e0_q;
        cur_e1_q <= pend_e1_q;
      end
      if (load_pend) begin
        pend_e0_q <= rs_e0;
        pend_e1_q <= rs_e1;
      end
    end
  end

  // Phase mux; the idle phase drives zero so a flushed stream shows no stale data
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      SEND0: begin
        out_valid = 1'b1;
        out_data  = cur_e0_q;
      end
      SEND1: begin
        out_valid = 1'b1;
        out_data  = cur_e1_q;
      end
      default: begin
        out_valid = 1'b0;
        out_data  = '0;
      end
    endcase
  end

`ifdef HB_SAT_STATS_EN
  logic [16:0] sat_sum;

  always_comb begin
    sat_sum = {1'b0, sat_cnt} + {16'd0, sat0} + {16'd0, sat1};
  end

  // Clamp counter advances by 0..2 per accepted pair and sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sync_clr) begin
      sat_cnt <= '0;
    end else if (accept) begin
      sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule
